// File: rtl/alu_issue_stage.sv
// alu_issue_stage: command FIFO + one-entry result slot feeding a 4-bit ALU.
// Optional sticky overflow flag enabled by defining STICKY_OVF_EN.
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_func,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_func,
  input  logic [3:0] alu_out,
  input  logic       alu_cout,
  input  logic       alu_ovf,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_out,
  output logic       res_cout,
  output logic       res_ovf,
  output logic [3:0] res_tag,
  output logic       ovf_sticky,
  input  logic       ovf_clr
);

  typedef enum logic {
    R_EMPTY,
    R_FULL
  } rstate_e;

  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  rstate_e       state_q, state_d;
  logic [3:0]    tag_q, tag_d;
  logic [3:0]    res_out_q, res_out_d;
  logic          res_cout_q, res_cout_d;
  logic          res_ovf_q, res_ovf_d;
  logic [3:0]    res_tag_q, res_tag_d;

  logic          empty;
  logic          push;
  logic          fire;
  logic [10:0]   head;

  assign empty     = (count_q == '0);
  assign cmd_ready = (count_q != (AW+1)'(DEPTH));
  assign res_valid = (state_q == R_FULL);
  assign push      = cmd_valid && cmd_ready;
  assign fire      = !empty && (!res_valid || res_ready);
  assign head      = mem_q[rd_ptr_q];

  assign alu_a    = empty ? 4'd0 : head[10:7];
  assign alu_b    = empty ? 4'd0 : head[6:3];
  assign alu_func = empty ? 3'd0 : head[2:0];

  assign res_out  = res_out_q;
  assign res_cout = res_cout_q;
  assign res_ovf  = res_ovf_q;
  assign res_tag  = res_tag_q;

  // Command storage; entries need no reset since count gates their use.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_a, cmd_b, cmd_func};
  end

  // Next-state for pointers, occupancy, slot FSM and tag counter.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    tag_d      = tag_q;
    res_out_d  = res_out_q;
    res_cout_d = res_cout_q;
    res_ovf_d  = res_ovf_q;
    res_tag_d  = res_tag_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (fire) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      res_out_d  = alu_out;
      res_cout_d = alu_cout;
      res_ovf_d  = alu_ovf;
      res_tag_d  = tag_q;
      tag_d      = tag_q + 4'd1;
      state_d    = R_FULL;
    end else if (state_q == R_FULL && res_ready) begin
      state_d = R_EMPTY;
    end
    unique case ({push, fire})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= R_EMPTY;
      tag_q      <= '0;
      res_out_q  <= '0;
      res_cout_q <= 1'b0;
      res_ovf_q  <= 1'b0;
      res_tag_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      tag_q      <= tag_d;
      res_out_q  <= res_out_d;
      res_cout_q <= res_cout_d;
      res_ovf_q  <= res_ovf_d;
      res_tag_q  <= res_tag_d;
    end
  end

`ifdef STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // Set on any overflowing capture; set beats a same-cycle clear.
  always_comb begin
    sticky_d = sticky_q;
    if (ovf_clr) sticky_d = 1'b0;
    if (fire && alu_ovf) sticky_d = 1'b1;
  end

  // Sticky flag register.
  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign ovf_sticky = sticky_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized bench for alu_issue_stage with a
// queue-based reference model and a behavioural stand-in ALU.
module tb_alu_issue_stage;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a, cmd_b;
  logic [2:0] cmd_func;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_func;
  logic [3:0] alu_out;
  logic       alu_cout, alu_ovf;
  logic       res_valid, res_ready;
  logic [3:0] res_out;
  logic       res_cout, res_ovf;
  logic [3:0] res_tag;
  logic       ovf_sticky, ovf_clr;

  always #5 clk = ~clk;

  alu_issue_stage #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_func(cmd_func),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_out(res_out), .res_cout(res_cout), .res_ovf(res_ovf),
    .res_tag(res_tag),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  typedef struct packed {
    logic [3:0] out;
    logic       c;
    logic       v;
    logic [3:0] tag;
  } exp_t;

  // Stand-in ALU: add, sub, and, or, xor, a, b, ~a.
  function automatic exp_t alu_ref(logic [3:0] a, logic [3:0] b,
                                   logic [2:0] f);
    exp_t r;
    int   s;
    r = '0;
    case (f)
      3'd0: begin
        s = int'(a) + int'(b);
        r.out = s[3:0];
        r.c = s > 15;
        r.v = (a[3] == b[3]) && (r.out[3] != a[3]);
      end
      3'd1: begin
        s = int'(a) + int'(~b) + 1;
        r.out = s[3:0];
        r.c = s > 15;
        r.v = (a[3] != b[3]) && (r.out[3] != a[3]);
      end
      default: begin
        case (f)
          3'd2: r.out = a & b;
          3'd3: r.out = a | b;
          3'd4: r.out = a ^ b;
          3'd5: r.out = a;
          3'd6: r.out = b;
          default: r.out = ~a;
        endcase
        r.c = a[3];
        r.v = b[3];
      end
    endcase
    return r;
  endfunction

  exp_t alu_now;
  assign alu_now  = alu_ref(alu_a, alu_b, alu_func);
  assign alu_out  = alu_now.out;
  assign alu_cout = alu_now.c;
  assign alu_ovf  = alu_now.v;

  // Reference model: queue of pending results plus the output slot.
  exp_t       mq[$];
  exp_t       slot;
  logic       slot_v;
  logic [3:0] mtag;
  logic       msticky;
  int         n_cmp = 0;
  int         n_bad = 0;

`ifdef STICKY_OVF_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    logic f, p;
    exp_t e;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      slot = '0; slot_v = 1'b0; mtag = '0; msticky = 1'b0;
    end else begin
      f = (mq.size() != 0) && (!slot_v || res_ready);
      p = cmd_valid && (mq.size() < DEPTH);
      if (STICKY && ovf_clr) msticky = 1'b0;
      if (f) begin
        slot = mq.pop_front();
        slot_v = 1'b1;
        if (STICKY && slot.v) msticky = 1'b1;
      end else if (slot_v && res_ready) begin
        slot_v = 1'b0;
      end
      if (p) begin
        e = alu_ref(cmd_a, cmd_b, cmd_func);
        e.tag = mtag;
        mtag = mtag + 4'd1;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0; ovf_clr = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_func = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic rand_cmd();
    cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_func = 3'($urandom);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({res_valid, cmd_ready, res_tag, ovf_sticky, res_out,
         res_cout, res_ovf} !== {1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 2'b00}) begin
      n_bad++;
      $display("FAIL reset: got v=%b rdy=%b tag=%0d stk=%b out=%0d c=%b o=%b need 0 1 0 0 0 0 0",
               res_valid, cmd_ready, res_tag, ovf_sticky, res_out,
               res_cout, res_ovf);
    end
    n_cmp++;
    if ({alu_a, alu_b, alu_func} !== 11'd0) begin
      n_bad++;
      $display("FAIL empty_alu_drive: got %h/%h/%h need 0/0/0",
               alu_a, alu_b, alu_func);
    end
  endtask

  task automatic test_basic();
    do_reset();
    res_ready = 1'b1;
    cmd_a = 4'd3; cmd_b = 4'd5; cmd_func = 3'd0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n_cmp++;
    if ({res_valid, alu_a, alu_b, alu_func} !== {1'b0, 4'd3, 4'd5, 3'd0}) begin
      n_bad++;
      $display("FAIL head_cycle: got v=%b a=%0d b=%0d f=%0d need 0 3 5 0",
               res_valid, alu_a, alu_b, alu_func);
    end
    tick();
    n_cmp++;
    if ({res_valid, res_out, res_cout, res_tag} !== {1'b1, 4'd8, 1'b0, 4'd0}) begin
      n_bad++;
      $display("FAIL add_3_5: got v=%b out=%0d c=%b tag=%0d need 1 8 0 0",
               res_valid, res_out, res_cout, res_tag);
    end
    cmd_a = 4'd7; cmd_b = 4'd1; cmd_func = 3'd0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    n_cmp++;
    if ({res_valid, res_out, res_ovf, res_tag, ovf_sticky}
        !== {1'b1, 4'd8, 1'b1, 4'd1, STICKY}) begin
      n_bad++;
      $display("FAIL add_7_1: got v=%b out=%0d ovf=%b tag=%0d stk=%b need 1 8 1 1 %b",
               res_valid, res_out, res_ovf, res_tag, ovf_sticky, STICKY);
    end
    tick();
    n_cmp++;
    if (ovf_sticky !== STICKY) begin
      n_bad++;
      $display("FAIL sticky_hold: got %b need %b", ovf_sticky, STICKY);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++;
    if (ovf_sticky !== 1'b0) begin
      n_bad++;
      $display("FAIL sticky_clr: got %b need 0", ovf_sticky);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_cmd();
      cmd_valid = 1'b1;
      n_cmp++;
      if (cmd_ready !== (i < 5)) begin
        n_bad++;
        $display("FAIL bp_ready[%0d]: got %b need %b", i, cmd_ready, i < 5);
      end
      tick();
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({res_valid, res_tag, res_out, res_cout, res_ovf}
          !== {1'b1, 4'd0, slot.out, slot.c, slot.v}) begin
        n_bad++;
        $display("FAIL bp_hold: got v=%b tag=%0d out=%0d c=%b o=%b need 1 0 %0d %b %b",
                 res_valid, res_tag, res_out, res_cout, res_ovf,
                 slot.out, slot.c, slot.v);
      end
      tick();
    end
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({res_valid, res_tag, res_out} !== {1'b1, 4'(k), slot.out}) begin
        n_bad++;
        $display("FAIL bp_drain[%0d]: got v=%b tag=%0d out=%0d need 1 %0d %0d",
                 k, res_valid, res_tag, res_out, k, slot.out);
      end
      tick();
    end
    n_cmp++;
    if ({res_valid, cmd_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_empty: got v=%b rdy=%b need 0 1", res_valid, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cmd_valid = (i < 20);
      if (cmd_valid) rand_cmd();
      if (res_valid) begin
        n_cmp++;
        if ({res_tag, res_out, res_cout, res_ovf}
            !== {4'(seen % 16), slot.out, slot.c, slot.v}) begin
          n_bad++;
          $display("FAIL b2b_res[%0d]: got tag=%0d out=%0d need tag=%0d out=%0d",
                   seen, res_tag, res_out, seen % 16, slot.out);
        end
        seen++;
      end
      if (i >= 2 && i < 22) begin
        n_cmp++;
        if ({res_valid, cmd_ready} !== 2'b11) begin
          n_bad++;
          $display("FAIL b2b_flow[%0d]: got v=%b rdy=%b need 1 1",
                   i, res_valid, cmd_ready);
        end
      end
      tick();
    end
    n_cmp++;
    if (seen !== 20) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d need 20", seen);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(3) != 0);
      rand_cmd();
      res_ready = ($urandom_range(2) != 0);
      ovf_clr   = ($urandom_range(7) == 0);
      n_cmp++;
      if ({res_valid, cmd_ready, res_out, res_cout, res_ovf, res_tag, ovf_sticky}
          !== {slot_v, mq.size() < DEPTH, slot.out, slot.c, slot.v,
               slot.tag, msticky}) begin
        n_bad++;
        $display("FAIL random[%0d]: got v=%b rdy=%b out=%0d c=%b o=%b tag=%0d stk=%b need %b %b %0d %b %b %0d %b",
                 i, res_valid, cmd_ready, res_out, res_cout, res_ovf,
                 res_tag, ovf_sticky, slot_v, mq.size() < DEPTH,
                 slot.out, slot.c, slot.v, slot.tag, msticky);
      end
      tick();
    end
    cmd_valid = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_cmd();
      cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if ({res_valid, cmd_ready} !== {1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL pre_reset: got v=%b rdy=%b need 1 1", res_valid, cmd_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({res_valid, cmd_ready, res_tag} !== {1'b0, 1'b1, 4'd0}) begin
      n_bad++;
      $display("FAIL mid_reset: got v=%b rdy=%b tag=%0d need 0 1 0",
               res_valid, cmd_ready, res_tag);
    end
    res_ready = 1'b1;
    rand_cmd();
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    n_cmp++;
    if ({res_valid, res_tag, res_out} !== {1'b1, 4'd0, slot.out}) begin
      n_bad++;
      $display("FAIL post_reset: got v=%b tag=%0d out=%0d need 1 0 %0d",
               res_valid, res_tag, res_out, slot.out);
    end
    tick();
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL post_drain: got v=%b need 0", res_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
